utype_decode_stage: RTL and testbench
=====================================

# utype_decode_stage

U-type decode stage with an ID/EX output buffer. It accepts a raw 32-bit instruction and its PC from the fetch side and recognises LUI/AUIPC. It then produces the operands the Execution-cycle U-type unit consumes: `pc`, `imm_u` and the 6-bit `aluSelect` code, together with writeback control. A two-entry skid buffer gives one-cycle latency, full throughput and fully registered backpressure.

## Interface
- No parameters; all widths fixed (XLEN 32).
- `clk`  in  1  single clock; rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `flush`  in  1  discard all buffered instructions (branch redirect).
- `in_valid`  in  1  instruction/PC pair valid.
- `in_ready`  out  1  stage can accept; registered.
- `in_pc`  in  32  PC of instruction.
- `in_inst`  in  32  raw instruction word.
- `out_valid`  out  1  decoded entry valid.
- `out_ready`  in  1  EX stage accepts.
- `out_pc`  out  32  passthrough PC.
- `out_imm_u`  out  32  `{inst[31:12], 12'b0}`.
- `out_aluSelect`  out  6  000001 = LUI, 000010 = AUIPC, 000000 = not U-type.
- `out_rd`  out  5  `inst[11:7]`.
- `out_wen`  out  1  register writeback enable.
- `out_illegal`  out  1  opcode is neither LUI nor AUIPC.
- `dec_count`  out  16  count of U-type instructions handed to EX; wraps.

## Operation
- **Opcode decode** (`inst[6:0]`):
  - 0110111 → LUI (aluSelect 000001).
  - 0010111 → AUIPC (aluSelect 000010).
  - Any other opcode → aluSelect 000000, illegal 1, wen 0. The instruction is still passed through, never dropped.
- **Writeback enable:** `wen = is_utype & (rd != 0)`. `imm_u` is always formed from `inst[31:12]`, even when illegal.
- **Decode timing:** decode is combinational on the input side. Results are captured into the registers; outputs come only from register M.
- **Storage:**
  - Main register M drives all `out_*` signals.
  - Skid register S holds one overflow entry.
  - `in_ready` is a registered `~S_valid`.
- **Handshakes:** accept = `in_valid & in_ready`; fire = `out_valid & out_ready`.
- **Next-state rules** (when not flushing):
  - If M is empty or fires, and S is valid: M←S, S becomes empty. An input accepted this cycle goes to S.
  - If M is empty or fires, and S is empty: M←input if accepted, else M becomes empty.
  - If M is full and does not fire: an accepted input goes to S.
- **Ordering:** program order is always preserved; no entry is duplicated or lost.
- **`dec_count`:** +1 on each fire where `out_aluSelect != 0`. It wraps 0xFFFF → 0x0000 and is not affected by flush.
- **Flush:** M_valid and S_valid clear at the next edge. Any input presented during the flush cycle is dropped, and `in_ready` is 1 on the following cycle. A fire in the flush cycle still completes and is counted.
- **Priority:** `rst_n` low > `flush` > normal operation.

## Timing
- **Reset values:** `out_valid` 0, `in_ready` 1, `out_pc`/`out_imm_u` 0, `out_aluSelect` 0, `out_rd` 0, `out_wen` 0, `out_illegal` 0, `dec_count` 0, S empty. Reset mid-stream discards both entries.
- **Latency:** an instruction accepted at edge N is presented on `out_*` after edge N (one cycle), provided M was empty or fired at N.
- **Throughput:** one instruction per cycle when `out_ready` is held at 1.
- **Stall:** with `out_ready` 0, two accepts fill M then S, and `in_ready` drops after the second.
- **Stable output:** `out_*` is unchanged while `out_valid & ~out_ready`.
- **Resume:** on `out_ready` rising with S full, `in_ready` returns to 1 one cycle after the first fire.
- Simultaneous accept and fire with S empty keeps M occupied with the new entry, with no bubble.

## Test plan
- **Reset:** hold `rst_n` = 0 for 2 cycles with `in_valid` = 1 → `out_valid` 0, `in_ready` 1, `dec_count` 0, all payload outputs 0.
- **Back-to-back decode:**
  - Stimulus: `out_ready` = 1; inst 0x12345237 @ pc 0x00000100, then 0x00001097 @ pc 0x00001000.
  - Required: first output imm 0x12345000, aluSelect 000001, rd 4, wen 1. Second output on the next cycle: imm 0x00001000, aluSelect 000010, rd 1, wen 1. `dec_count` reaches 2.
- **Non-U-type and x0 destination:** inst 0x00000013 → illegal 1, aluSelect 000000, wen 0, `dec_count` unchanged. Inst 0x00001037 → aluSelect 000001, rd 0, wen 0, `dec_count` +1.
- **Backpressure:**
  - Stimulus: `out_ready` = 0; present 3 LUIs on consecutive cycles.
  - Required: first two accepted, `in_ready` 0 on the third and it is held. After `out_ready` = 1, all three emerge in order on three consecutive cycles with payloads unchanged.
- **Flush:** with M and S full, assert `flush` together with a new `in_valid` → next cycle `out_valid` 0, `in_ready` 1, and the flush-cycle input never appears.
- **Counter wrap:** preload `dec_count` to 0xFFFE via 65534 AUIPCs (or force), then issue 3 more → sequence 0xFFFF, 0x0000, 0x0001.

Source files
------------

// File: rtl/utype_decode_stage.sv
// ---------------------------------------------------------------------------
// utype_decode_stage
//
// Decodes LUI / AUIPC from a raw 32-bit instruction and hands the operands to
// the EX-stage U-type unit through a two-entry skid buffer. The skid buffer
// gives one-cycle latency, full throughput and a registered in_ready.
//
// Ports
//   clk           in   1   clock, rising edge
//   rst_n         in   1   synchronous active-low reset
//   flush         in   1   discard every buffered entry (branch redirect)
//   in_valid      in   1   instruction / PC pair valid
//   in_ready      out  1   stage can accept (registered, equals ~S valid)
//   in_pc         in   32  PC of the instruction
//   in_inst       in   32  raw instruction word
//   out_valid     out  1   decoded entry valid
//   out_ready     in   1   EX stage accepts
//   out_pc        out  32  passthrough PC
//   out_imm_u     out  32  {inst[31:12], 12'b0}
//   out_aluSelect out  6   000001 LUI, 000010 AUIPC, 000000 other
//   out_rd        out  5   inst[11:7]
//   out_wen       out  1   writeback enable (U-type and rd != 0)
//   out_illegal   out  1   opcode is neither LUI nor AUIPC
//   dec_count     out  16  U-type instructions handed to EX, wraps
// ---------------------------------------------------------------------------
module utype_decode_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_inst,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_imm_u,
  output logic [5:0]  out_aluSelect,
  output logic [4:0]  out_rd,
  output logic        out_wen,
  output logic        out_illegal,
  output logic [15:0] dec_count
);

  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [5:0] SEL_NONE  = 6'b000000;
  localparam logic [5:0] SEL_LUI   = 6'b000001;
  localparam logic [5:0] SEL_AUIPC = 6'b000010;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] imm_u;
    logic [5:0]  alu_sel;
    logic [4:0]  rd;
    logic        wen;
    logic        illegal;
  } entry_t;

  entry_t      in_entry;
  entry_t      m_entry_reg, m_entry_next;
  entry_t      s_entry_reg, s_entry_next;
  logic        m_valid_reg, m_valid_next;
  logic        s_valid_reg, s_valid_next;
  logic        in_ready_reg, in_ready_next;
  logic [15:0] dec_count_reg, dec_count_next;
  logic        accept;
  logic        fire;
  logic        is_utype;

  // Input-side decode. Non-U-type opcodes still travel down the pipe,
  // flagged illegal and with writeback suppressed.
  always_comb begin
    in_entry       = '0;
    in_entry.pc    = in_pc;
    in_entry.imm_u = {in_inst[31:12], 12'b0};
    in_entry.rd    = in_inst[11:7];
    case (in_inst[6:0])
      OP_LUI:   in_entry.alu_sel = SEL_LUI;
      OP_AUIPC: in_entry.alu_sel = SEL_AUIPC;
      default:  in_entry.alu_sel = SEL_NONE;
    endcase
    is_utype         = (in_entry.alu_sel != SEL_NONE);
    in_entry.illegal = ~is_utype;
    in_entry.wen     = is_utype & (in_inst[11:7] != 5'd0);
  end

  assign accept = in_valid & in_ready_reg;
  assign fire   = m_valid_reg & out_ready;

  always_comb begin
    m_entry_next   = m_entry_reg;
    s_entry_next   = s_entry_reg;
    m_valid_next   = m_valid_reg;
    s_valid_next   = s_valid_reg;
    dec_count_next = dec_count_reg;

    // A fire completes even in a flush cycle, so it is always counted.
    if (fire && (m_entry_reg.alu_sel != SEL_NONE)) begin
      dec_count_next = dec_count_reg + 16'd1;
    end

    if (flush) begin
      m_valid_next = 1'b0;
      s_valid_next = 1'b0;
    end else if (!m_valid_reg || fire) begin
      if (s_valid_reg) begin
        // Older skid entry moves up first to keep program order.
        m_entry_next = s_entry_reg;
        m_valid_next = 1'b1;
        s_valid_next = accept;
        if (accept) begin
          s_entry_next = in_entry;
        end
      end else begin
        m_valid_next = accept;
        if (accept) begin
          m_entry_next = in_entry;
        end
      end
    end else if (accept) begin
      // M stalled: accept can only happen with S empty, so S takes it.
      s_entry_next = in_entry;
      s_valid_next = 1'b1;
    end

    in_ready_next = ~s_valid_next;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      m_entry_reg   <= '0;
      s_entry_reg   <= '0;
      m_valid_reg   <= 1'b0;
      s_valid_reg   <= 1'b0;
      in_ready_reg  <= 1'b1;
      dec_count_reg <= 16'd0;
    end else begin
      m_entry_reg   <= m_entry_next;
      s_entry_reg   <= s_entry_next;
      m_valid_reg   <= m_valid_next;
      s_valid_reg   <= s_valid_next;
      in_ready_reg  <= in_ready_next;
      dec_count_reg <= dec_count_next;
    end
  end

  assign in_ready      = in_ready_reg;
  assign out_valid     = m_valid_reg;
  assign out_pc        = m_entry_reg.pc;
  assign out_imm_u     = m_entry_reg.imm_u;
  assign out_aluSelect = m_entry_reg.alu_sel;
  assign out_rd        = m_entry_reg.rd;
  assign out_wen       = m_entry_reg.wen;
  assign out_illegal   = m_entry_reg.illegal;
  assign dec_count     = dec_count_reg;

endmodule

// File: tb/tb_utype_decode_stage.sv
module tb_utype_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_inst;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_imm_u;
  logic [5:0]  out_aluSelect;
  logic [4:0]  out_rd;
  logic        out_wen;
  logic        out_illegal;
  logic [15:0] dec_count;

  utype_decode_stage dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_pc        (in_pc),
    .in_inst      (in_inst),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_pc       (out_pc),
    .out_imm_u    (out_imm_u),
    .out_aluSelect(out_aluSelect),
    .out_rd       (out_rd),
    .out_wen      (out_wen),
    .out_illegal  (out_illegal),
    .dec_count    (dec_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] imm;
    logic [5:0]  sel;
    logic [4:0]  rd;
    logic        wen;
    logic        ill;
  } exp_t;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    exp_t        e;
  } vec_t;

  int          n_chk  = 0;
  int          n_fail = 0;
  bit          verbose = 1'b1;
  exp_t        sb_q[$];
  exp_t        drv_exp;
  exp_t        mon_e;
  logic [15:0] exp_cnt = 16'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Reference decode used for the generated stimulus.
  function automatic exp_t model(input logic [31:0] inst, input logic [31:0] pc);
    exp_t e;
    e.pc  = pc;
    e.imm = {inst[31:12], 12'h000};
    e.rd  = inst[11:7];
    if (inst[6:0] == 7'h37)      e.sel = 6'd1;
    else if (inst[6:0] == 7'h17) e.sel = 6'd2;
    else                         e.sel = 6'd0;
    e.ill = (e.sel == 6'd0);
    e.wen = !e.ill && (e.rd != 5'd0);
    return e;
  endfunction

  // Scoreboard: push on accept, pop and compare on fire, track the counter.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb_q.delete();
      exp_cnt = 16'd0;
    end else begin
      chk("dec_count", {16'h0, dec_count}, {16'h0, exp_cnt});
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_out", 32'd1, 32'd0);
        end else begin
          mon_e = sb_q.pop_front();
          chk("out_pc", out_pc, mon_e.pc);
          chk("out_imm_u", out_imm_u, mon_e.imm);
          chk("out_aluSelect", {26'h0, out_aluSelect}, {26'h0, mon_e.sel});
          chk("out_rd", {27'h0, out_rd}, {27'h0, mon_e.rd});
          chk("out_wen", {31'h0, out_wen}, {31'h0, mon_e.wen});
          chk("out_illegal", {31'h0, out_illegal}, {31'h0, mon_e.ill});
          if (mon_e.sel != 6'd0) exp_cnt = exp_cnt + 16'd1;
          if (verbose)
            $display("OUT pc=%h imm=%h sel=%b rd=%0d wen=%b ill=%b",
                     out_pc, out_imm_u, out_aluSelect, out_rd, out_wen, out_illegal);
        end
      end
      if (flush) sb_q.delete();
      else if (in_valid && in_ready) sb_q.push_back(drv_exp);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one instruction and returns after the edge that accepted it.
  task automatic send(input logic [31:0] inst, input logic [31:0] pc, input exp_t e,
                      output int waits);
    logic acc;
    acc      = 1'b0;
    waits    = 0;
    in_valid = 1'b1;
    in_inst  = inst;
    in_pc    = pc;
    drv_exp  = e;
    for (int t = 0; t < 20; t++) begin
      acc = in_ready;
      step();
      if (acc) break;
      waits++;
    end
    if (!acc) chk("send_timeout", 32'd1, 32'd0);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((sb_q.size() != 0 || out_valid) && t < 50) begin
      step();
      t++;
    end
    chk("drain_done", {31'h0, (sb_q.size() == 0 && !out_valid)}, 32'd1);
  endtask

  vec_t        vecs[7];
  exp_t        e_a, e_b, e_c;
  int          w;
  logic [31:0] snap_pc, snap_imm;
  logic [15:0] wrap_exp[3];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{32'h12345237, 32'h00000100, '{32'h00000100, 32'h12345000, 6'd1, 5'd4,  1'b1, 1'b0}};
    vecs[1] = '{32'h00001097, 32'h00001000, '{32'h00001000, 32'h00001000, 6'd2, 5'd1,  1'b1, 1'b0}};
    vecs[2] = '{32'h00000013, 32'h00001004, '{32'h00001004, 32'h00000000, 6'd0, 5'd0,  1'b0, 1'b1}};
    vecs[3] = '{32'h00001037, 32'h00001008, '{32'h00001008, 32'h00001000, 6'd1, 5'd0,  1'b0, 1'b0}};
    vecs[4] = '{32'hFFFFF2B7, 32'h0000100C, '{32'h0000100C, 32'hFFFFF000, 6'd1, 5'd5,  1'b1, 1'b0}};
    vecs[5] = '{32'h80000F97, 32'h00001010, '{32'h00001010, 32'h80000000, 6'd2, 5'd31, 1'b1, 1'b0}};
    vecs[6] = '{32'hABCDE0B3, 32'h00001014, '{32'h00001014, 32'hABCDE000, 6'd0, 5'd1,  1'b0, 1'b1}};

    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
    in_valid = 1'b1; in_inst = 32'h12345237; in_pc = 32'h00000100;
    drv_exp = vecs[0].e;

    // Reset held two cycles with in_valid high.
    step(); step();
    chk("rst_out_valid", {31'h0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'h0, in_ready}, 32'd1);
    chk("rst_dec_count", {16'h0, dec_count}, 32'd0);
    chk("rst_out_pc", out_pc, 32'd0);
    chk("rst_out_imm_u", out_imm_u, 32'd0);
    chk("rst_out_aluSelect", {26'h0, out_aluSelect}, 32'd0);
    chk("rst_out_rd", {27'h0, out_rd}, 32'd0);
    chk("rst_out_wen", {31'h0, out_wen}, 32'd0);
    chk("rst_out_illegal", {31'h0, out_illegal}, 32'd0);
    in_valid = 1'b0;
    rst_n = 1'b1;
    step();

    // Table vectors streamed back-to-back with out_ready high.
    out_ready = 1'b1;
    foreach (vecs[i]) begin
      send(vecs[i].inst, vecs[i].pc, vecs[i].e, w);
      chk("tput_no_wait", w, 32'd0);
      chk("latency_valid", {31'h0, out_valid}, 32'd1);
      chk("latency_pc", out_pc, vecs[i].pc);
    end
    drain();
    chk("table_count", {16'h0, dec_count}, 32'd5);

    // Backpressure: three LUIs with out_ready low.
    out_ready = 1'b0;
    e_a = model(32'h00011237, 32'h00002000);
    e_b = model(32'h000222B7, 32'h00002004);
    e_c = model(32'h00033337, 32'h00002008);
    in_valid = 1'b1; in_inst = 32'h00011237; in_pc = 32'h00002000; drv_exp = e_a;
    step();
    chk("bp_ready_after_1", {31'h0, in_ready}, 32'd1);
    in_inst = 32'h000222B7; in_pc = 32'h00002004; drv_exp = e_b;
    step();
    chk("bp_ready_after_2", {31'h0, in_ready}, 32'd0);
    in_inst = 32'h00033337; in_pc = 32'h00002008; drv_exp = e_c;
    snap_pc = out_pc; snap_imm = out_imm_u;
    step();
    chk("bp_ready_held", {31'h0, in_ready}, 32'd0);
    chk("bp_stable_pc", out_pc, snap_pc);
    chk("bp_stable_imm", out_imm_u, snap_imm);
    chk("bp_head_pc", out_pc, 32'h00002000);
    step();
    chk("bp_stable_pc2", out_pc, snap_pc);
    out_ready = 1'b1;
    step();
    chk("bp_resume_ready", {31'h0, in_ready}, 32'd1);
    chk("bp_second_pc", out_pc, 32'h00002004);
    step();
    in_valid = 1'b0;
    chk("bp_third_pc", out_pc, 32'h00002008);
    drain();

    // Flush with M and S full plus a new input in the flush cycle.
    out_ready = 1'b0;
    send(32'h00044437, 32'h00003000, model(32'h00044437, 32'h00003000), w);
    send(32'h00055537, 32'h00003004, model(32'h00055537, 32'h00003004), w);
    chk("fl_full", {31'h0, in_ready}, 32'd0);
    flush = 1'b1; in_valid = 1'b1; in_inst = 32'h00066637; in_pc = 32'h00003008;
    drv_exp = model(32'h00066637, 32'h00003008);
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_out_valid", {31'h0, out_valid}, 32'd0);
    chk("fl_in_ready", {31'h0, in_ready}, 32'd1);
    step(); step();
    chk("fl_dropped", {31'h0, out_valid}, 32'd0);

    // Flush with a fire in the same cycle and S empty: fire counts, input dropped.
    send(32'h00077797, 32'h00003100, model(32'h00077797, 32'h00003100), w);
    out_ready = 1'b1;
    flush = 1'b1; in_valid = 1'b1; in_inst = 32'h00088837; in_pc = 32'h00003104;
    drv_exp = model(32'h00088837, 32'h00003104);
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl2_out_valid", {31'h0, out_valid}, 32'd0);
    chk("fl2_count", {16'h0, dec_count}, 32'd9);
    step();
    chk("fl2_dropped", {31'h0, out_valid}, 32'd0);

    // Counter wrap: stream AUIPCs up to 0xFFFE, then three more.
    verbose = 1'b0;
    in_valid = 1'b1; in_inst = 32'h00000097; in_pc = 32'h00004000;
    drv_exp = model(32'h00000097, 32'h00004000);
    for (int t = 0; t < 70000 && exp_cnt + {15'h0, out_valid} + 16'd1 != 16'hFFFF; t++) begin
      step();
    end
    in_valid = 1'b0;
    drain();
    verbose = 1'b1;
    chk("wrap_preload", {16'h0, dec_count}, 32'h0000FFFE);
    wrap_exp[0] = 16'hFFFF; wrap_exp[1] = 16'h0000; wrap_exp[2] = 16'h0001;
    for (int i = 0; i < 3; i++) begin
      send(32'h00000097, 32'h00005000 + 32'(i * 4), model(32'h00000097, 32'h00005000 + 32'(i * 4)), w);
      step();
      chk("wrap_count", {16'h0, dec_count}, {16'h0, wrap_exp[i]});
    end
    drain();

    // Reset mid-stream discards both entries and the counter.
    out_ready = 1'b0;
    send(32'h00099937, 32'h00006000, model(32'h00099937, 32'h00006000), w);
    send(32'h000AAA37, 32'h00006004, model(32'h000AAA37, 32'h00006004), w);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("mrst_out_valid", {31'h0, out_valid}, 32'd0);
    chk("mrst_in_ready", {31'h0, in_ready}, 32'd1);
    chk("mrst_dec_count", {16'h0, dec_count}, 32'd0);
    out_ready = 1'b1;
    step(); step();
    chk("mrst_empty", {31'h0, out_valid}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
